// File: rtl/flash_cmd_controller.sv
// flash_cmd_controller: decodes host opcode/address bytes and sequences
// page-program, sequential-read and page-erase against the memory array.
module flash_cmd_controller #(
  parameter int ADDR_WIDTH   = 16,
  parameter int PAGE_SIZE    = 32,
  parameter int ERASE_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byteValid,
  input  logic [7:0]            byteIn,
  input  logic                  readByteReq,
  input  logic                  stop,
  output logic                  readEnable,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memWrite,
  output logic                  memRead,
  output logic                  memErase,
  output logic                  busy,
  output logic                  cmdError
);
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_ERASE = 8'hD8;
  localparam int CW = ERASE_CYCLES > 1 ? $clog2(ERASE_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] PMASK = ADDR_WIDTH'(PAGE_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] AONE  = ADDR_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, WRITE_DATA, READ_DATA, ERASE_BUSY} state_t;
  state_t                r_state, w_state_nx;
  logic [7:0]            r_op, w_op_nx, r_hi, w_hi_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx, w_load, w_pg_inc;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic                  r_we, r_wr, r_rd, r_err;
  logic                  w_we_nx, w_wr_nx, w_rd_nx, w_err_nx, w_op_ok;
  assign w_load   = ADDR_WIDTH'({r_hi, byteIn});
  // program addresses wrap inside the page; upper bits stay put
  assign w_pg_inc = (r_addr & ~PMASK) | ((r_addr + AONE) & PMASK);
  assign w_op_ok  = (byteIn == OP_WRITE) || (byteIn == OP_READ) || (byteIn == OP_ERASE);
  assign readEnable  = r_state != READ_DATA;
  assign memErase    = r_state == ERASE_BUSY;
  assign busy        = r_state == ERASE_BUSY;
  assign writeEnable = r_we;
  assign memWrite    = r_wr;
  assign memRead     = r_rd;
  assign cmdError    = r_err;
  assign memAddr     = r_addr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_hi    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_op    <= w_op_nx;
      r_hi    <= w_hi_nx;
      r_addr  <= w_addr_nx;
      r_cnt   <= w_cnt_nx;
      r_we    <= w_we_nx;
      r_wr    <= w_wr_nx;
      r_rd    <= w_rd_nx;
      r_err   <= w_err_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_op_nx    = r_op;
    w_hi_nx    = r_hi;
    w_cnt_nx   = r_cnt;
    // the address advances in the cycle following each program/read strobe
    w_addr_nx  = r_wr ? w_pg_inc : r_rd ? r_addr + AONE : r_addr;
    w_we_nx    = 1'b0;
    w_wr_nx    = 1'b0;
    w_rd_nx    = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      IDLE: if (byteValid && !stop) begin
        w_op_nx    = w_op_ok ? byteIn : r_op;
        w_we_nx    = w_op_ok;
        w_err_nx   = !w_op_ok;
        w_state_nx = w_op_ok ? ADDR_HI : IDLE;
      end
      ADDR_HI: begin
        w_err_nx   = stop;
        w_hi_nx    = (byteValid && !stop) ? byteIn : r_hi;
        w_state_nx = stop ? IDLE : byteValid ? ADDR_LO : ADDR_HI;
      end
      ADDR_LO: begin
        w_err_nx = stop;
        if (stop) w_state_nx = IDLE;
        else if (byteValid) begin
          w_addr_nx  = r_op == OP_ERASE ? w_load & ~PMASK : w_load;
          w_cnt_nx   = CW'(ERASE_CYCLES - 1);
          w_state_nx = r_op == OP_WRITE ? WRITE_DATA : r_op == OP_READ ? READ_DATA : ERASE_BUSY;
        end
      end
      WRITE_DATA: begin
        w_wr_nx    = byteValid && !stop;
        w_state_nx = stop ? IDLE : WRITE_DATA;
      end
      READ_DATA: begin
        w_rd_nx    = readByteReq && !stop;
        w_state_nx = stop ? IDLE : READ_DATA;
      end
      ERASE_BUSY: begin
        w_err_nx   = byteValid;
        w_cnt_nx   = r_cnt == '0 ? r_cnt : r_cnt - CW'(1);
        w_state_nx = r_cnt == '0 ? IDLE : ERASE_BUSY;
      end
      default: w_state_nx = IDLE;
    endcase
  end
endmodule

// File: doc/flash_cmd_controller.md
Name: flash_cmd_controller

Overview:
- Command sequencer for the I2C flash memory model.
- Consumes deserialised host bytes, decodes the opcode, collects a 16-bit address and then runs page-program, sequential-read or page-erase.
- Drives the direction/capture controls of the data buffer (readEnable, writeEnable) and the memory array strobes (memAddr, memWrite, memRead, memErase).
- Sits between the I2C byte deserialiser and the data buffer / memory array.

Parameters:
ADDR_WIDTH, 16, memory address width; address bytes are masked to this width
PAGE_SIZE, 32, bytes per page (power of 2); sets program wrap and erase granularity
ERASE_CYCLES, 64, clock cycles memErase is held per erase (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
byteValid  input  1  one-cycle strobe: byteIn holds a new host byte
byteIn  input  8  host byte (opcode, address or write data)
readByteReq  input  1  one-cycle strobe: host clocks out the next read byte
stop  input  1  one-cycle strobe: I2C STOP, ends the transaction
readEnable  output  1  buffer direction: 1 = host-to-memory (write), 0 = memory-to-host (read)
writeEnable  output  1  one-cycle pulse: buffer captures the opcode into its control register
memAddr  output  ADDR_WIDTH  current array address
memWrite  output  1  one-cycle program strobe
memRead  output  1  one-cycle read strobe
memErase  output  1  held high during erase
busy  output  1  high while an erase is in progress
cmdError  output  1  one-cycle pulse on a protocol error

Behaviour:
- Reset values (asynchronous, take effect immediately): state IDLE, readEnable=1, all other outputs 0, memAddr=0, internal opcode/counter 0.
- Opcodes: 0x02 WRITE, 0x03 READ, 0xD8 ERASE.
- States: IDLE, ADDR_HI, ADDR_LO, WRITE_DATA, READ_DATA, ERASE_BUSY.
- IDLE:
  - byteValid with a valid opcode: latch the opcode, pulse writeEnable on the next cycle, go to ADDR_HI.
  - Invalid opcode: pulse cmdError, stay in IDLE, no writeEnable.
- ADDR_HI / ADDR_LO:
  - byteValid loads the high byte, then the low byte; memAddr = {hi,lo} masked to ADDR_WIDTH, updated on the ADDR_LO accept.
  - After ADDR_LO: WRITE -> WRITE_DATA, READ -> READ_DATA, ERASE -> ERASE_BUSY.
- WRITE_DATA:
  - readEnable=1.
  - Each byteValid: memWrite=1 the next cycle with memAddr = target.
  - memAddr then advances in the cycle after the strobe. The low log2(PAGE_SIZE) bits increment mod PAGE_SIZE; upper bits are unchanged (page wrap).
  - readByteReq is ignored.
- READ_DATA:
  - readEnable=0 from the first cycle in the state.
  - Each readByteReq: memRead=1 the next cycle at the current memAddr, then memAddr increments mod 2^ADDR_WIDTH (full wrap, 0xFFFF -> 0x0000).
  - byteValid is ignored (no error).
- ERASE_BUSY:
  - On entry, memAddr = page base (low bits cleared); memErase=1 and busy=1 for exactly ERASE_CYCLES cycles, then return to IDLE with both low.
  - byteValid during ERASE_BUSY: byte dropped, cmdError pulses.
  - stop is ignored (erase completes).
- stop in any other state: state is IDLE on the next cycle, readEnable returns to 1.
  - stop in ADDR_HI or ADDR_LO also pulses cmdError (incomplete command).
  - stop in WRITE_DATA or READ_DATA is a normal end.
- Simultaneous stop + byteValid: stop wins; the byte is dropped; no memWrite.
- Simultaneous byteValid + readByteReq: only the one legal in the current state acts.
- Reset mid-erase: memErase and busy drop immediately; no resume.
- Strobes (writeEnable, memWrite, memRead, cmdError) are never high for more than one consecutive cycle per triggering event.

Test Plan:
- Reset asserted mid-sequence -> all outputs 0, readEnable=1, state IDLE within the same cycle; 0x55 opcode after release -> single cmdError pulse, no writeEnable.
- Bytes 0x02,0x12,0x3E then data A,B,C -> writeEnable pulse after 0x02; memWrite at 0x123E, 0x123F, 0x1220 (page wrap); stop -> IDLE.
- Bytes 0x03,0xFF,0xFF, three readByteReq -> readEnable=0, memRead at 0xFFFF, 0x0000, 0x0001; stop -> readEnable=1.
- Bytes 0xD8,0x04,0x47 -> memAddr=0x0440, memErase/busy high exactly 64 cycles; byteValid mid-erase -> cmdError pulse, erase length unchanged.
- Bytes 0x02,0x10 then stop -> cmdError pulse, IDLE, no memWrite; in WRITE_DATA, stop and byteValid in the same cycle -> no memWrite, IDLE.
- Reset pulse during ERASE_BUSY -> memErase and busy low immediately; next 0x03 command operates normally.
